// File: rtl/uartprobe_uart_rx.sv
// UART receive front-end: oversampled 8N1 (or 8E1 with UARTPROBE_RX_PARITY_EN) de-framer
// feeding a one-byte valid/ready holding register with framing/overrun/parity pulses.
`timescale 1ns/1ps
module uartprobe_uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       m_aresetn,
   input  logic       uart_rx,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);

`ifdef UARTPROBE_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

   state_t        state, state_n;
   logic [1:0]    sync;
   logic          rxs;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic          done, ferr;

   assign rxs = sync[1];

`ifdef UARTPROBE_RX_PARITY_EN
   logic par, par_n, par_bad, par_bad_n, perr;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      bit_n   = bit_idx;
      shift_n = shift;
      done    = 1'b0;
      ferr    = 1'b0;
`ifdef UARTPROBE_RX_PARITY_EN
      par_n     = par;
      par_bad_n = par_bad;
      perr      = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rxs) state_n = START;
         end
         START: if (cnt == HALF_M1) begin
            cnt_n = '0;
            if (rxs) begin
               state_n = IDLE;
            end else begin
               state_n = DATA;
               bit_n   = '0;
`ifdef UARTPROBE_RX_PARITY_EN
               par_n     = 1'b0;
               par_bad_n = 1'b0;
`endif
            end
         end
         DATA: if (cnt == LAST) begin
            cnt_n   = '0;
            shift_n = {rxs, shift[7:1]};
            bit_n   = bit_idx + 3'd1;
`ifdef UARTPROBE_RX_PARITY_EN
            par_n = par ^ rxs;
            if (bit_idx == 3'd7) state_n = PARITY;
`else
            if (bit_idx == 3'd7) state_n = STOP;
`endif
         end
`ifdef UARTPROBE_RX_PARITY_EN
         PARITY: if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = STOP;
            if (par ^ rxs) begin
               perr      = 1'b1;
               par_bad_n = 1'b1;
            end
         end
`endif
         STOP: if (cnt == LAST) begin
            cnt_n = '0;
            if (!rxs) begin
               ferr    = 1'b1;
               state_n = BREAK;
            end else begin
               // leave mid-stop-bit so a fast sender's next start edge is not missed
               state_n = IDLE;
`ifdef UARTPROBE_RX_PARITY_EN
               done = !par_bad;
`else
               done = 1'b1;
`endif
            end
         end
         BREAK: begin
            cnt_n = '0;
            if (rxs) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge m_aresetn) begin
      if (!m_aresetn) begin
         sync      <= '1;
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sync      <= {sync[0], uart_rx};
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_n;
         shift     <= shift_n;
         frame_err <= ferr;
         overrun   <= 1'b0;
         if (done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

`ifdef UARTPROBE_RX_PARITY_EN
   always_ff @(posedge clk or negedge m_aresetn) begin
      if (!m_aresetn) begin
         par        <= 1'b0;
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par        <= par_n;
         par_bad    <= par_bad_n;
         parity_err <= perr;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uartprobe_uart_rx.sv
// Scoreboard bench for uartprobe_uart_rx at CLKS_PER_BIT=16; stimulus pushes expected
// bytes / error events, a monitor pops them on handshakes and error pulses.
`timescale 1ns/1ps
module tb_uartprobe_uart_rx;
   localparam int CPB = 16;
`ifdef UARTPROBE_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   // negedge index (after frame start) at which rx_valid / pulses first read high
   localparam int RISE = 3 + CPB / 2 + (9 + PAR) * CPB;

   logic       clk = 1'b0;
   logic       m_aresetn = 1'b0;
   logic       uart_rx = 1'b1;
   logic       ready_drv = 1'b0;
   logic       tie = 1'b0;
   logic       rx_ready;
   logic       rx_valid, frame_err, overrun, parity_err;
   logic [7:0] rx_data;

   assign rx_ready = tie ? rx_valid : ready_drv;
   always #5 clk = ~clk;

   uartprobe_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .m_aresetn(m_aresetn), .uart_rx(uart_rx),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
   );

   int         nvec = 0;
   int         nmis = 0;
   logic [7:0] exp_q[$];
   int         err_q[$];
   int         n_valid = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic pop_err(input int code);
      if (err_q.size() == 0) begin
         nvec++;
         nmis++;
         $display("FAIL unexpected_error_pulse: got code %0d expected none", code);
      end else begin
         chk("error_kind", code, err_q.pop_front());
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (m_aresetn) begin
         if (rx_valid) n_valid++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               nvec++;
               nmis++;
               $display("FAIL unexpected_byte: got %0h expected none", rx_data);
            end else begin
               chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
         end
         if (frame_err)  pop_err(1);
         if (overrun)    pop_err(2);
         if (parity_err) pop_err(3);
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic p, input logic stop, input int nstop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      if (PAR != 0) begin
         uart_rx = p;
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB * nstop) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, ^b, 1'b1, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int v0;
      repeat (3) @(negedge clk);
      chk("reset_valid", {31'h0, rx_valid}, 32'h0);
      chk("reset_data", {24'h0, rx_data}, 32'h0);
      chk("reset_ferr", {31'h0, frame_err}, 32'h0);
      chk("reset_overrun", {31'h0, overrun}, 32'h0);
      chk("reset_perr", {31'h0, parity_err}, 32'h0);
      m_aresetn = 1'b1;
      repeat (4) @(negedge clk);

      // A5 with rx_ready low: exact rise time, hold, then single accept
      exp_q.push_back(8'hA5);
      fork
         send_byte(8'hA5);
         begin
            repeat (RISE - 1) @(negedge clk);
            chk("a5_valid_before_rise", {31'h0, rx_valid}, 32'h0);
            @(negedge clk);
            chk("a5_valid_rise", {31'h0, rx_valid}, 32'h1);
            chk("a5_data_at_rise", {24'h0, rx_data}, 32'hA5);
         end
      join
      repeat (20) @(negedge clk);
      chk("a5_valid_held", {31'h0, rx_valid}, 32'h1);
      ready_drv = 1'b1;
      @(negedge clk);
      ready_drv = 1'b0;
      chk("a5_valid_clear", {31'h0, rx_valid}, 32'h0);

      // back-to-back with ready tied to valid
      tie = 1'b1;
      v0 = n_valid;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      send_byte(8'h12);
      send_byte(8'h34);
      repeat (30) @(negedge clk);
      chk("b2b_valid_cycles", n_valid - v0, 2);

      // overrun: second byte dropped, first held
      tie = 1'b0;
      exp_q.push_back(8'h55);
      err_q.push_back(2);
      send_byte(8'h55);
      fork
         send_byte(8'hAA);
         begin
            repeat (RISE - 1) @(negedge clk);
            chk("ovr_before", {31'h0, overrun}, 32'h0);
            @(negedge clk);
            chk("ovr_pulse", {31'h0, overrun}, 32'h1);
            @(negedge clk);
            chk("ovr_one_cycle", {31'h0, overrun}, 32'h0);
         end
      join
      chk("ovr_data_kept", {24'h0, rx_data}, 32'h55);
      ready_drv = 1'b1;
      @(negedge clk);
      ready_drv = 1'b0;
      chk("ovr_valid_clear", {31'h0, rx_valid}, 32'h0);

      // framing error: stop low for 3 bit times, then recovery
      tie = 1'b1;
      v0 = n_valid;
      err_q.push_back(1);
      send_frame(8'hC3, ^8'hC3, 1'b0, 3);
      repeat (2 * CPB) @(negedge clk);
      chk("ferr_no_valid", n_valid - v0, 0);
      exp_q.push_back(8'h3C);
      send_byte(8'h3C);
      repeat (30) @(negedge clk);

      // 4-cycle glitch: false start, then a normal byte still decodes
      v0 = n_valid;
      uart_rx = 1'b0;
      repeat (4) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      chk("glitch_no_valid", n_valid - v0, 0);
      exp_q.push_back(8'h81);
      send_byte(8'h81);
      repeat (30) @(negedge clk);

`ifdef UARTPROBE_RX_PARITY_EN
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b1, 1);
      repeat (30) @(negedge clk);
      v0 = n_valid;
      err_q.push_back(3);
      send_frame(8'h07, 1'b0, 1'b1, 1);
      repeat (30) @(negedge clk);
      chk("perr_no_valid", n_valid - v0, 0);
`endif

      chk("bytes_outstanding", exp_q.size(), 0);
      chk("errors_outstanding", err_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule

// File: doc/uartprobe_uart_rx.md
# uartprobe_uart_rx

UART receive front-end for the UART probe. Oversamples the asynchronous `uart_rx` pin, de-frames 8-bit LSB-first characters, and presents each byte on a valid/ready interface consumed by the probe command FSM. Sits between the board pin and the probe's `rx_valid`/`rx_data`/`rx_ready` channel. Reports framing, overrun and (optionally) parity errors as single-cycle pulses.

## Interface

- `CLKS_PER_BIT`, 868, clk cycles per UART bit; legal range 4..65535 (868 = 100 MHz / 115200 baud).
- `clk`  in  1  system clock.
- `m_aresetn`  in  1  reset, asynchronous, active-low; clock clk.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `rx_valid`  out  1  byte available in `rx_data`.
- `rx_data`  out  8  received byte, stable while `rx_valid`=1.
- `rx_ready`  in  1  consumer accepts byte this cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped, holding register full.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; constant 0 without `UARTPROBE_RX_PARITY_EN`.

## Operation

- `uart_rx` passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value `rxs`.
- States: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: on `rxs`=0 go to START and clear the bit counter. Call that cycle T0.
- HALF = CLKS_PER_BIT/2 (integer division). Sample points are T0+HALF+k·CLKS_PER_BIT.
  - k=0: start bit. If `rxs`=1, false start: back to IDLE, no output.
  - k=1..8: data bits, LSB first, into a shift register.
  - k=9: parity (macro only).
  - Last k: stop bit.
- Stop sample = 1, parity OK (or disabled): byte completes. Go to IDLE immediately, mid-stop-bit, to absorb baud mismatch.
- Stop sample = 0: pulse `frame_err`, drop the byte, go to BREAK. BREAK returns to IDLE on the first cycle `rxs`=1.
- Holding register:
  - A completed byte loads `rx_data` and sets `rx_valid` if `rx_valid`=0, or if `rx_valid & rx_ready` in the same cycle (back-to-back load; `rx_valid` stays 1, no overrun).
  - Otherwise the byte is dropped, `overrun` pulses, and `rx_data` keeps the old byte.
- `rx_valid` clears on `rx_valid & rx_ready` when no byte completes that cycle. `rx_ready` while `rx_valid`=0 is ignored.
- Reset values: `rx_valid`=0, `rx_data`=8'h00, `frame_err`=`overrun`=`parity_err`=0, state IDLE.
- Reset mid-frame aborts the frame and discards partial data. After release, an in-progress low level re-detects as a start bit; the bench does not depend on that frame's content.

## Timing

- Bit counter width is clog2(CLKS_PER_BIT). It wraps to 0 at each sample point.
- Pin falling edge to T0: 2–3 cycles (synchronizer).
- `rx_valid` rises on the cycle after the stop sample, i.e. T0+HALF+9·CLKS_PER_BIT+1 (add CLKS_PER_BIT with parity).
- Error pulses are asserted on the cycle after the offending sample and last exactly 1 cycle.
- Accepted baud mismatch: ±4% at 8N1.
- No combinational path from `rx_ready` to any output.

## Configuration

- `UARTPROBE_RX_PARITY_EN` defined:
  - Frames are 8E1; the parity bit is sampled at k=9 and the stop bit at k=10.
  - Odd count of ones over data plus parity: pulse `parity_err`, drop the byte, return to IDLE after the stop sample.
  - A low stop bit still gives `frame_err` instead of completion, and goes to BREAK.
- Undefined: 8N1, no PARITY state, `parity_err` tied 0, port still present.

## Test plan

- CLKS_PER_BIT=16: send 8'hA5 (8N1), `rx_ready`=0 -> `rx_valid`=1 with `rx_data`=8'hA5 at T0+8+144+1, held until `rx_ready` pulse; clears the next cycle.
- Send 8'h12 then 8'h34 back-to-back, `rx_ready` tied to `rx_valid` -> two single-cycle `rx_valid` pulses carrying 8'h12 then 8'h34, no errors.
- Send 8'h55 and 8'hAA with `rx_ready`=0 -> `rx_data` stays 8'h55, one `overrun` pulse at the second stop sample+1.
- Stop bit driven low for 3 bit times -> `frame_err` single pulse, no `rx_valid`. A following 8'h3C after line high is received correctly.
- 4-cycle low glitch on idle line -> false start, no outputs, state back to IDLE.
- With `UARTPROBE_RX_PARITY_EN`: 8'h07 with parity bit 1 -> `rx_data`=8'h07. Same byte with parity 0 -> `parity_err` pulse, no `rx_valid`.
